// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO written over the data bus,
// serialised LSB first on txd, with a level interrupt once all queued data has gone out.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        int_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_d;
  logic [15:0]    cnt, cnt_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [7:0]     shift, shift_d;
  logic           txd_d;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           tx_en, int_en;
  logic [15:0]    divisor;

  logic           wr_en, push, push_ok, pop, full, empty, busy;
  logic [1:0]     reg_sel;
  logic           unused_bits;

  assign reg_sel = addr[3:2];
  assign wr_en   = ce & we;
  assign push    = wr_en & (reg_sel == REG_TXDATA) & sel[0];
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  // A full FIFO still accepts a byte when the transmitter pops on the same edge.
  assign push_ok = push & (~full | pop);

  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:1], data_i[31:16]};

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= data_i[7:0];
        wptr      <= AW'(wptr + 1'b1);
      end
      if (pop) begin
        rptr <= AW'(rptr + 1'b1);
      end
      case ({push_ok, pop})
        2'b10:   count <= CW'(count + 1'b1);
        2'b01:   count <= CW'(count - 1'b1);
        default: count <= count;
      endcase
      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end else if (wr_en && (reg_sel == REG_STATUS) && data_i[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Control and baud divisor registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en   <= 1'b0;
      int_en  <= 1'b0;
      divisor <= DIV_RESET;
    end else if (wr_en) begin
      if (reg_sel == REG_CTRL) begin
        tx_en  <= data_i[0];
        int_en <= data_i[1];
      end
      if (reg_sel == REG_DIVISOR) begin
        divisor <= data_i[15:0];
      end
    end
  end

  // Transmit state register; txd is retimed one clock behind the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      txd     <= txd_d;
    end
  end

  // Next-state logic; every bit period reloads from the live divisor
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_en && !empty) begin
          pop       = 1'b1;
          shift_d   = mem[rptr];
          cnt_d     = divisor;
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (cnt == 16'd0) begin
          cnt_d   = divisor;
          state_d = DATA;
        end else begin
          cnt_d = 16'(cnt - 16'd1);
        end
      end
      DATA: begin
        txd_d = shift[0];
        if (cnt == 16'd0) begin
          cnt_d   = divisor;
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = 3'(bit_idx + 3'd1);
          end
        end else begin
          cnt_d = 16'(cnt - 16'd1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (cnt == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = 16'(cnt - 16'd1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign int_o = int_en & empty & ~busy;

  // Read mux; zero whenever the peripheral is not being read
  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      case (reg_sel)
        REG_STATUS:  data_o = {24'd0, 4'(count), overflow, busy, empty, full};
        REG_CTRL:    data_o = {30'd0, int_en, tx_en};
        REG_DIVISOR: data_o = {16'd0, divisor};
        default:     data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register vector table, directed corner sequences and
// randomized frames checked against a waveform model built from the 8N1 framing rules.
module tb_uart_tx_mmio;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        txd;
  logic        int_o;

  int passed = 0;
  int total  = 0;

  uart_tx_mmio dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .sel    (sel),
    .data_i (data_i),
    .data_o (data_o),
    .txd    (txd),
    .int_o  (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        rd_ce;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = {28'd0, a, 2'b00}; data_i = d; sel = s;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; addr = '0; data_i = '0; sel = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = {28'd0, a, 2'b00};
    #1;
    d = data_o;
    ce = 1'b0; addr = '0;
  endtask

  // Expected line level per clock for a burst of frames: start, 8 data LSB first,
  // stop, each div+1 clocks, with one idle clock between consecutive frames.
  task automatic run_frames(input string tag, input logic [7:0] bytes[$], input int div);
    logic e[$];
    int   k;
    for (int i = 0; i < bytes.size(); i++) begin
      logic [7:0] b;
      b = bytes[i];
      repeat (div + 1) e.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (div + 1) e.push_back(b[j]);
      repeat (div + 1) e.push_back(1'b1);
      if (i + 1 < bytes.size()) e.push_back(1'b1);
    end
    k = 0;
    while (txd !== 1'b0 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_start"}, {31'd0, txd}, 32'd0);
    if (txd !== 1'b0) return;
    for (int j = 0; j < e.size(); j++) begin
      check($sformatf("%s_txd[%0d]", tag, j), {31'd0, txd}, {31'd0, e[j]});
      if (j + 1 < e.size()) begin
        @(posedge clk); #1;
      end
    end
  endtask

  logic [31:0] rd;
  logic [7:0]  q[$];
  int          div;
  int          n;
  int          lows;

  initial begin
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_int", {31'd0, int_o}, 32'd0);
    bus_read(2'd3, rd); check("rst_divisor", rd, 32'd433);
    bus_read(2'd1, rd); check("rst_status", rd, 32'h002);
    @(negedge clk); rst = 1'b1;

    // Register access table
    vecs[0] = '{1'b1, 2'd3, 32'hABCD1234, 1'b1, 32'h0000_1234, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 32'hFFFFFFF2, 1'b1, 32'h0000_0002, 1'b1};
    vecs[2] = '{1'b0, 2'd2, 32'h0,        1'b0, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b1, 2'd2, 32'h0,        1'b1, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 32'h0,        1'b1, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 32'h3,        1'b1, 32'h0000_0003, 1'b0};
    vecs[6] = '{1'b0, 2'd1, 32'h0,        1'b1, 32'h0000_0002, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 32'hFFFFFFFF, 1'b1, 32'h0000_0002, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].wd, 4'hF);
      ce = vecs[i].rd_ce; we = 1'b0; addr = {28'd0, vecs[i].a, 2'b00};
      #1;
      check($sformatf("vec%0d_rd", i), data_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_int", i), {31'd0, int_o}, {31'd0, vecs[i].exp_int});
      ce = 1'b0; addr = '0;
    end

    // TXDATA write with sel[0]=0 is ignored
    bus_write(2'd0, 32'h55, 4'hE);
    bus_read(2'd1, rd); check("sel0_ignored", rd, 32'h002);

    // Single frame 0xA5 at DIVISOR=3 with push-to-start latency
    bus_write(2'd2, 32'h1, 4'hF);
    bus_write(2'd0, 32'hA5, 4'hF);
    check("lat_w0", {31'd0, txd}, 32'd1);
    @(posedge clk); #1; check("lat_w1", {31'd0, txd}, 32'd1);
    bus_read(2'd1, rd); check("busy_mid", rd & 32'h4, 32'h4);
    @(posedge clk); #1; check("lat_w2", {31'd0, txd}, 32'd0);
    q = '{8'hA5};
    run_frames("a5", q, 3);
    @(posedge clk); #1;
    bus_read(2'd1, rd); check("a5_done_status", rd, 32'h002);

    // Overflow with transmitter disabled, then drain four frames back to back
    bus_write(2'd2, 32'h0, 4'hF);
    for (int i = 1; i <= 5; i++) bus_write(2'd0, 32'(i), 4'hF);
    bus_read(2'd1, rd); check("ovf_status", rd, 32'h049);
    bus_write(2'd2, 32'h1, 4'hF);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frames("burst", q, 3);
    @(posedge clk); #1;
    bus_read(2'd1, rd); check("burst_ovf_kept", rd, 32'h00A);
    bus_write(2'd1, 32'h8, 4'hF);
    bus_read(2'd1, rd); check("ovf_clear", rd, 32'h002);

    // Push into a full FIFO on the same edge as the pop
    bus_write(2'd2, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h10 + 32'(i), 4'hF);
    bus_write(2'd2, 32'h1, 4'hF);
    bus_write(2'd0, 32'h14, 4'hF);
    bus_read(2'd1, rd); check("full_pop_push", rd, 32'h045);
    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    run_frames("fullpop", q, 3);

    // Interrupt: high while idle and empty, low after a push, back high after the frame
    @(posedge clk); #1;
    bus_write(2'd2, 32'h3, 4'hF);
    check("int_idle", {31'd0, int_o}, 32'd1);
    bus_write(2'd0, 32'h3C, 4'hF);
    @(posedge clk); #1; check("int_after_push", {31'd0, int_o}, 32'd0);
    repeat (39) begin @(posedge clk); #1; end
    check("int_last_stop", {31'd0, int_o}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("int_after_frame", {31'd0, int_o}, 32'd1);

    // Reset pulse in the middle of a data bit
    bus_write(2'd2, 32'h1, 4'hF);
    bus_write(2'd0, 32'h00, 4'hF);
    bus_write(2'd0, 32'h55, 4'hF);
    repeat (9) begin @(posedge clk); #1; end
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 rst = 1'b0;
    #1 check("async_rst_txd", {31'd0, txd}, 32'd1);
    bus_read(2'd1, rd); check("rst_mid_status", rd, 32'h002);
    bus_read(2'd2, rd); check("rst_mid_ctrl", rd, 32'h0);
    @(negedge clk); rst = 1'b1;
    lows = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);

    // Randomized bursts against the framing model
    for (int it = 0; it < 6; it++) begin
      div = int'($urandom_range(0, 3));
      n   = int'($urandom_range(1, 4));
      q.delete();
      bus_write(2'd2, 32'h0, 4'hF);
      bus_write(2'd3, 32'(div), 4'hF);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        q.push_back(b);
        bus_write(2'd0, {24'd0, b}, 4'hF);
      end
      bus_read(2'd1, rd);
      check($sformatf("rnd%0d_status", it), rd, (32'(n) << 4) | ((n == 4) ? 32'h1 : 32'h0));
      bus_write(2'd2, 32'h1, 4'hF);
      run_frames($sformatf("rnd%0d", it), q, div);
      @(posedge clk); #1;
      bus_read(2'd1, rd); check($sformatf("rnd%0d_done", it), rd, 32'h002);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
